// File: rtl/regfile_sweep.sv
// rtl/regfile_sweep.sv - two-read/one-write register file with a multi-cycle clear sweep
//
// Purpose:
//   NUM_REGS x DATA_BUS_WIDTH register file. Reads are combinational and can
//   forward same-cycle write data. A clear request starts a sweep that zeroes
//   one register per cycle. Writes are refused while the sweep runs.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset (clears registers, aborts sweep)
//   wr_en      - write request
//   wr_sel     - write register index
//   wr_data    - write data
//   rd1_sel    - read port 1 index
//   rd2_sel    - read port 2 index
//   rd1_data   - read port 1 data (combinational)
//   rd2_data   - read port 2 data (combinational)
//   clear_req  - start a clear sweep (ignored while sweeping)
//   wr_ready   - high when a write can be accepted this cycle
//   busy       - high while the clear sweep is in progress
//   clear_done - one-cycle pulse after the final register is cleared

module regfile_sweep #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int NUM_REGS       = 8,
  parameter bit ZERO_REG0      = 1'b0,
  parameter bit BYPASS         = 1'b1,
  localparam int SEL_W         = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [DATA_BUS_WIDTH-1:0] wr_data,
  input  logic [SEL_W-1:0]          rd1_sel,
  input  logic [SEL_W-1:0]          rd2_sel,
  output logic [DATA_BUS_WIDTH-1:0] rd1_data,
  output logic [DATA_BUS_WIDTH-1:0] rd2_data,
  input  logic                      clear_req,
  output logic                      wr_ready,
  output logic                      busy,
  output logic                      clear_done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          cnt_q, cnt_d;
  logic                      clear_done_q, clear_done_d;
  logic [DATA_BUS_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_BUS_WIDTH-1:0] regs_d [NUM_REGS];

  logic wr_in_range;
  logic wr_qual;

  assign busy       = (state_q == SWEEP);
  assign wr_ready   = ~busy;
  assign clear_done = clear_done_q;

  // A write counts only when it will really land in storage; the same
  // qualifier gates bypass so a dropped write is never forwarded.
  always_comb begin
    wr_in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_sel == SEL_W'(i)) wr_in_range = 1'b1;
    end
    wr_qual = wr_en && wr_ready && wr_in_range && !(ZERO_REG0 && (wr_sel == '0));
  end

  // Index matching by loop keeps out-of-range selects (non power-of-two
  // NUM_REGS) from ever addressing the array; they fall through to 0.
  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd1_sel == SEL_W'(i)) rd1_data = regs_q[i];
      if (rd2_sel == SEL_W'(i)) rd2_data = regs_q[i];
    end
    if (BYPASS && wr_qual) begin
      if (rd1_sel == wr_sel) rd1_data = wr_data;
      if (rd2_sel == wr_sel) rd2_data = wr_data;
    end
    if (ZERO_REG0 && (rd1_sel == '0)) rd1_data = '0;
    if (ZERO_REG0 && (rd2_sel == '0)) rd2_data = '0;
  end

  always_comb begin
    regs_d       = regs_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_qual && (wr_sel == SEL_W'(i))) regs_d[i] = wr_data;
        end
        // The write of the request cycle commits before the sweep starts.
        if (clear_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (cnt_q == SEL_W'(i)) regs_d[i] = '0;
        end
        if (cnt_q == LAST_IDX) begin
          state_d      = IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
      regs_q       <= regs_d;
    end
  end

endmodule

// File: tb/tb_regfile_sweep.sv
// tb/tb_regfile_sweep.sv - self-checking bench for regfile_sweep (three configurations)
//
// Purpose:
//   Drives three instances from one stimulus stream and compares every output
//   against a cycle-numbered reference model of the register file.
//   dut_a: 8 regs, bypass on; dut_b: 8 regs, bypass off;
//   dut_c: 6 regs, register 0 hardwired to zero, bypass on.
//
// Ports: none (top-level bench).

module tb_regfile_sweep;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset     = 1'b1;
  logic       wr_en     = 1'b0;
  logic       clear_req = 1'b0;
  logic [2:0] wr_sel    = '0;
  logic [2:0] rd1_sel   = '0;
  logic [2:0] rd2_sel   = '0;
  logic [7:0] wr_data   = '0;

  logic [7:0] rd1_o [3];
  logic [7:0] rd2_o [3];
  logic       busy_o [3];
  logic       wr_ready_o [3];
  logic       clear_done_o [3];

  regfile_sweep #(.DATA_BUS_WIDTH(8), .NUM_REGS(8), .ZERO_REG0(1'b0), .BYPASS(1'b1)) dut_a (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .rd1_data(rd1_o[0]), .rd2_data(rd2_o[0]),
    .clear_req(clear_req), .wr_ready(wr_ready_o[0]), .busy(busy_o[0]), .clear_done(clear_done_o[0]));

  regfile_sweep #(.DATA_BUS_WIDTH(8), .NUM_REGS(8), .ZERO_REG0(1'b0), .BYPASS(1'b0)) dut_b (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .rd1_data(rd1_o[1]), .rd2_data(rd2_o[1]),
    .clear_req(clear_req), .wr_ready(wr_ready_o[1]), .busy(busy_o[1]), .clear_done(clear_done_o[1]));

  regfile_sweep #(.DATA_BUS_WIDTH(8), .NUM_REGS(6), .ZERO_REG0(1'b1), .BYPASS(1'b1)) dut_c (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .rd1_data(rd1_o[2]), .rd2_data(rd2_o[2]),
    .clear_req(clear_req), .wr_ready(wr_ready_o[2]), .busy(busy_o[2]), .clear_done(clear_done_o[2]));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  logic [7:0] mem [3][8];
  int sw_first [3];
  int busy_cnt, done_cnt;

  // Model: a sweep accepted at edge c is busy for cycles c+1 .. c+N; register
  // i is cleared at the end of cycle c+1+i; clear_done is high in cycle c+N+1.
  function automatic int nr(input int k);
    return (k == 2) ? 6 : 8;
  endfunction
  function automatic bit zr(input int k);
    return (k == 2);
  endfunction
  function automatic bit by(input int k);
    return (k != 1);
  endfunction
  function automatic bit m_busy(input int k);
    return (cyc >= sw_first[k]) && (cyc < sw_first[k] + nr(k));
  endfunction
  function automatic bit m_done(input int k);
    return cyc == sw_first[k] + nr(k);
  endfunction
  function automatic bit m_qual(input int k);
    return wr_en && !m_busy(k) && (int'(wr_sel) < nr(k)) && !(zr(k) && wr_sel == 3'd0);
  endfunction
  function automatic logic [7:0] m_read(input int k, input logic [2:0] sel);
    if (int'(sel) >= nr(k) || (zr(k) && sel == 3'd0)) return 8'h00;
    if (by(k) && m_qual(k) && wr_sel == sel) return wr_data;
    return mem[k][sel];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
      sw_first[k] = -1000;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive(input bit r, input bit we, input logic [2:0] ws, input logic [7:0] wd,
                       input logic [2:0] s1, input logic [2:0] s2, input bit cr);
    reset = r; wr_en = we; wr_sel = ws; wr_data = wd;
    rd1_sel = s1; rd2_sel = s2; clear_req = cr;
    if (r) model_reset();
    #1;
  endtask

  task automatic chk_model();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd1[%0d]", k), rd1_o[k], m_read(k, rd1_sel));
      chk($sformatf("rd2[%0d]", k), rd2_o[k], m_read(k, rd2_sel));
      chk($sformatf("busy[%0d]", k), {7'd0, busy_o[k]}, {7'd0, m_busy(k)});
      chk($sformatf("wr_ready[%0d]", k), {7'd0, wr_ready_o[k]}, {7'd0, !m_busy(k)});
      chk($sformatf("clear_done[%0d]", k), {7'd0, clear_done_o[k]}, {7'd0, m_done(k)});
    end
  endtask

  task automatic tick();
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (m_busy(k)) begin
          mem[k][cyc - sw_first[k]] = 8'h00;
        end else begin
          if (m_qual(k)) mem[k][wr_sel] = wr_data;
          if (clear_req) sw_first[k] = cyc + 1;
        end
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic step(input bit r, input bit we, input logic [2:0] ws, input logic [7:0] wd,
                      input logic [2:0] s1, input logic [2:0] s2, input bit cr);
    drive(r, we, ws, wd, s1, s2, cr);
    chk_model();
    tick();
  endtask

  initial begin
    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_model();
    chk("reset_busy", {7'd0, busy_o[0]}, 8'h00);
    chk("reset_wr_ready", {7'd0, wr_ready_o[0]}, 8'h01);
    tick();
    step(1, 0, 0, 0, 3, 5, 0);

    // Write with same-cycle read, with and without bypass
    drive(0, 1, 3, 8'hA5, 3, 3, 0);
    chk_model();
    chk("bypass_on", rd1_o[0], 8'hA5);
    chk("bypass_off", rd1_o[1], 8'h00);
    tick();
    drive(0, 0, 0, 0, 3, 3, 0);
    chk_model();
    chk("bypass_off_next", rd1_o[1], 8'hA5);
    tick();

    // Hardwired register 0 and out-of-range selects
    drive(0, 1, 0, 8'h7E, 0, 0, 0);
    chk_model();
    chk("zero_reg0_wcyc", rd2_o[2], 8'h00);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_model();
    chk("zero_reg0_after", rd2_o[2], 8'h00);
    tick();
    drive(0, 1, 7, 8'h5C, 7, 7, 0);
    chk_model();
    chk("oor_read_wcyc", rd1_o[2], 8'h00);
    tick();
    drive(0, 0, 0, 0, 7, 7, 0);
    chk_model();
    chk("oor_read_after", rd1_o[2], 8'h00);
    chk("in_range_7", rd1_o[0], 8'h5C);
    tick();

    // Full sweep with blocked write and ignored re-request
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 8'(8'h11 * (i + 1)), 3'(i), 2, 0);
    step(0, 0, 0, 0, 5, 2, 1);
    busy_cnt = 0; done_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      drive(0, (j == 3), 5, 8'hFF, 5, 2, (j == 1));
      chk_model();
      busy_cnt += int'(busy_o[0]);
      done_cnt += int'(clear_done_o[0]);
      if (j < 8) chk($sformatf("sweep_r2_j%0d", j), rd2_o[0], (j <= 2) ? 8'h33 : 8'h00);
      if (j == 3) chk("blocked_wr_ready", {7'd0, wr_ready_o[0]}, 8'h00);
      tick();
    end
    chk("sweep_busy_cycles", 8'(busy_cnt), 8'd8);
    chk("sweep_done_pulses", 8'(done_cnt), 8'd1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 3'(i), 3'(i), 0);
      chk_model();
      chk($sformatf("cleared_r%0d", i), rd1_o[0], 8'h00);
      tick();
    end

    // Write together with clear_req, then re-request on the done cycle
    step(0, 1, 7, 8'h42, 7, 7, 1);
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, 0, 0, 7, 0, (j == 8));
      chk_model();
      if (j < 9) chk($sformatf("r7_j%0d", j), rd1_o[0], (j <= 7) ? 8'h42 : 8'h00);
      if (j == 8) chk("done_cycle", {7'd0, clear_done_o[0]}, 8'h01);
      if (j == 9) chk("restart_busy", {7'd0, busy_o[0]}, 8'h01);
      tick();
    end
    for (int j = 0; j < 9; j++) step(0, 0, 0, 0, 3'(j), 3'(7 - j), 0);

    // Reset in the middle of a sweep
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 8'($urandom_range(1, 255)), 3'(i), 7, 0);
    step(0, 0, 0, 0, 6, 7, 1);
    for (int j = 0; j < 4; j++) step(0, 0, 0, 0, 6, 7, 0);
    drive(1, 0, 0, 0, 6, 7, 0);
    chk_model();
    chk("rst_mid_busy", {7'd0, busy_o[0]}, 8'h00);
    chk("rst_mid_r7", rd2_o[0], 8'h00);
    chk("rst_mid_r6", rd1_o[1], 8'h00);
    tick();
    done_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, 0, 0, 3'(j), 3'(j + 4), 0);
      chk_model();
      done_cnt += int'(clear_done_o[0]);
      tick();
    end
    chk("rst_no_done", 8'(done_cnt), 8'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 3'($urandom),
           8'($urandom), 3'($urandom), 3'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
